// File: rtl/npc_multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// npc_multicycle_ctrl_pkg
//   Shared definitions for the NPC multi-cycle sequencer: the 3-bit state
//   encoding, the trap-cause codes reported on trap_cause, default parameter
//   values and small state-classification helpers.
//
//   There are eight 3-bit codes and nine architectural states, so HALT and
//   TRAP share the single absorbing ST_STOP code. The latched cause tells them
//   apart: CAUSE_NONE in ST_STOP means an ebreak retired (halted). Any other
//   cause means a fault stop (trap).
// ----------------------------------------------------------------------------
package npc_multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,   // one idle cycle after reset
        ST_FETCH = 3'd1,   // instruction request outstanding
        ST_IWAIT = 3'd2,   // waiting for instruction word
        ST_EXEC  = 3'd3,   // decode / ALU settle
        ST_MREQ  = 3'd4,   // load/store request outstanding
        ST_MWAIT = 3'd5,   // waiting for load data / store ack
        ST_WB    = 3'd6,   // commit PC / RF, count retirement
        ST_STOP  = 3'd7    // halted or trapped, absorbing until rst
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_BUSERR  = 2'b11
    } cause_e;

    localparam int unsigned DEF_TIMEOUT_CYC = 1024;
    localparam int unsigned DEF_CNT_W       = 32;

    // States in which the sequencer waits on an external handshake. The
    // timeout counter advances only here.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_IWAIT) ||
               (s == ST_MREQ)  || (s == ST_MWAIT);
    endfunction

    // States whose outgoing edge carries a memory transfer.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_MREQ) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/npc_seq_timeout.sv
// ----------------------------------------------------------------------------
// npc_seq_timeout
//   Wait-state watchdog for the multi-cycle sequencer. The counter clears
//   whenever the sequencer changes state and advances on every enabled cycle.
//   expired_o is raised in the cycle where the count has reached
//   TIMEOUT_CYC-1, that is, the TIMEOUT_CYC-th consecutive cycle in the same
//   wait state. The sequencer then traps on the next edge unless the awaited
//   handshake arrives in that same cycle.
//
// Ports
//   clk        in   core clock, rising edge
//   rst        in   asynchronous reset, active-high
//   clr_i      in   sequencer changes state this cycle
//   en_i       in   sequencer is in a wait state
//   expired_o  out  wait budget used up in this cycle
// ----------------------------------------------------------------------------
module npc_seq_timeout
    import npc_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The count cannot wrap. Expiry always forces a state change, and that
    // change clears the count on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/npc_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// npc_multicycle_ctrl
//   Multi-cycle sequencer for the NPC core. It steps one instruction at a
//   time through FETCH -> IWAIT -> EXEC -> (MREQ -> MWAIT) -> WB. It drives
//   the IFU and LSU request handshakes and produces the IR/PC/RF write
//   enables. Every output is decoded from registered state, with one
//   exception: ir_we follows the qualified instruction response in IWAIT.
//
// Ports
//   clk, rst         core clock (rising edge), async active-high reset
//   ifu_req_valid    out  fetch request (FETCH)
//   ifu_req_ready    in   IFU accepts request
//   ifu_rsp_valid    in   instruction word valid
//   ifu_rsp_err      in   fetch bus error (qualified by ifu_rsp_valid)
//   lsu_req_valid    out  load/store request (MREQ)
//   lsu_req_wr       out  1=store, 0=load, valid while lsu_req_valid
//   lsu_req_ready    in   LSU accepts request
//   lsu_rsp_valid    in   load data / store ack
//   lsu_rsp_err      in   data bus error (qualified by lsu_rsp_valid)
//   dec_*            in   decoder control bits, sampled in EXEC
//   ir_we            out  latch instruction register
//   pc_we            out  commit next PC (WB)
//   rf_we            out  register file write (WB, loads and ALU ops)
//   halted           out  sticky, ebreak retired
//   trap             out  sticky, fault stop
//   trap_cause       out  01 illegal, 10 timeout, 11 bus error, 00 if no trap
//   retired          out  retired-instruction count, wraps at 2^CNT_W
// ----------------------------------------------------------------------------
module npc_multicycle_ctrl
    import npc_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic             ifu_rsp_err,
    output logic             lsu_req_valid,
    output logic             lsu_req_wr,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    input  logic             dec_rd_wr,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_illegal,
    input  logic             dec_ebreak,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    cause_e           cause_q, cause_d;
    logic             store_q, store_d;   // instruction is a store
    logic             rfw_q,   rfw_d;     // instruction writes rd in WB
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             tmo_expired;
    logic             in_stop;

    npc_seq_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .en_i      (is_wait_state(state_q)),
        .expired_o (tmo_expired)
    );

    // Next-state logic. In every wait state the awaited handshake is tested
    // before expiry, so a handshake in the expiry cycle wins.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        store_d   = store_q;
        rfw_d     = rfw_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (ifu_req_ready) begin
                    state_d = ST_IWAIT;
                end else if (tmo_expired) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_IWAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_d = ST_STOP;
                        cause_d = CAUSE_BUSERR;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            // The decoder bits are captured here. lsu_req_wr and rf_we then
            // come from flops rather than from the decoder inputs. When both
            // mem_rd and mem_wr are set, the access is treated as a store.
            ST_EXEC: begin
                store_d = dec_mem_wr;
                rfw_d   = dec_rd_wr & ~dec_mem_wr;
                if (dec_illegal) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_NONE;
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_d = ST_MREQ;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MREQ: begin
                if (lsu_req_ready) begin
                    state_d = ST_MWAIT;
                end else if (tmo_expired) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_MWAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_d = ST_STOP;
                        cause_d = CAUSE_BUSERR;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_STOP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            ST_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end

            ST_STOP: begin
                state_d = ST_STOP;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            cause_q   <= CAUSE_NONE;
            store_q   <= 1'b0;
            rfw_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            store_q   <= store_d;
            rfw_q     <= rfw_d;
            retired_q <= retired_d;
        end
    end

    // Output decode
    assign in_stop       = (state_q == ST_STOP);

    assign ifu_req_valid = (state_q == ST_FETCH);
    assign ir_we         = (state_q == ST_IWAIT) && ifu_rsp_valid && !ifu_rsp_err;
    assign lsu_req_valid = (state_q == ST_MREQ);
    assign lsu_req_wr    = (state_q == ST_MREQ) && store_q;
    assign pc_we         = (state_q == ST_WB);
    assign rf_we         = (state_q == ST_WB) && rfw_q;
    assign halted        = in_stop && (cause_q == CAUSE_NONE);
    assign trap          = in_stop && (cause_q != CAUSE_NONE);
    assign trap_cause    = trap ? cause_q : CAUSE_NONE;
    assign retired       = retired_q;

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
module tb_npc_multicycle_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic lsu_req_valid, lsu_req_wr, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    logic dec_rd_wr, dec_mem_rd, dec_mem_wr, dec_illegal, dec_ebreak;
    logic ir_we, pc_we, rf_we, halted, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;

    npc_multicycle_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_wr(lsu_req_wr),
        .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_err(lsu_rsp_err),
        .dec_rd_wr(dec_rd_wr), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
        .dec_illegal(dec_illegal), .dec_ebreak(dec_ebreak),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .halted(halted), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rd_wr, mem_rd, mem_wr, illegal, ebreak, ifu_err, lsu_err;
        int   ifu_dly, rsp_dly, lsu_dly, lsu_rsp_dly;
        logic exp_rf, exp_mem, exp_wr, exp_halt;
        logic [1:0] exp_cause;
    } vec_t;

    typedef struct {
        logic          rf;
        logic [CW-1:0] ret;
    } sb_t;

    sb_t           sb_q[$];
    vec_t          ret_tab[10];
    vec_t          stop_tab[7];
    logic [CW-1:0] exp_ret;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic vec_t mk(input logic rd, mr, mw, ill, eb, ie, le,
                                input int idl, rdl, ldl, lrdl,
                                input logic erf, emem, ewr, ehalt,
                                input logic [1:0] ecause);
        vec_t v;
        v.rd_wr = rd; v.mem_rd = mr; v.mem_wr = mw; v.illegal = ill;
        v.ebreak = eb; v.ifu_err = ie; v.lsu_err = le;
        v.ifu_dly = idl; v.rsp_dly = rdl; v.lsu_dly = ldl; v.lsu_rsp_dly = lrdl;
        v.exp_rf = erf; v.exp_mem = emem; v.exp_wr = ewr; v.exp_halt = ehalt;
        v.exp_cause = ecause;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every WB cycle must match the oldest pushed entry.
    task automatic sb_monitor();
        sb_t e;
        chk("rf_we_only_in_wb", int'(rf_we & ~pc_we), 0);
        if (pc_we) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_wb", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rf_we", rf_we, e.rf);
                chk("wb_retired_before", retired, e.ret);
            end
        end
    endtask

    // Returns at posedge+1 of the next cycle.
    task automatic tick();
        @(negedge clk);
        sb_monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
        lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
        dec_rd_wr = 0; dec_mem_rd = 0; dec_mem_wr = 0; dec_illegal = 0; dec_ebreak = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifu_req_valid"}, ifu_req_valid, 0);
        chk({tag, "_lsu_req_valid"}, lsu_req_valid, 0);
        chk({tag, "_lsu_req_wr"}, lsu_req_wr, 0);
        chk({tag, "_ir_we"}, ir_we, 0);
        chk({tag, "_pc_we"}, pc_we, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_trap_cause"}, trap_cause, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    // Leaves the DUT in its BOOT cycle, at posedge+1.
    task automatic do_reset();
        clear_inputs();
        rst = 1;
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        exp_ret = '0;
        chk("boot_no_req", ifu_req_valid, 0);
    endtask

    task automatic check_stop(input vec_t v);
        chk("stop_halted", halted, v.exp_halt);
        chk("stop_trap", trap, int'(v.exp_cause != 2'b00));
        chk("stop_cause", trap_cause, v.exp_cause);
        chk("stop_retired", retired, exp_ret);
        for (int k = 0; k < 3; k++) begin
            chk("stop_no_ifu_req", ifu_req_valid, 0);
            chk("stop_no_lsu_req", lsu_req_valid, 0);
            chk("stop_no_pc_we", pc_we, 0);
            tick();
        end
        chk("stop_sticky", {halted, trap, trap_cause},
            {v.exp_halt, (v.exp_cause != 2'b00), v.exp_cause});
        do_reset();
    endtask

    task automatic run_instr(input vec_t v);
        int  n;
        bit  retires;
        retires = !v.exp_halt && (v.exp_cause == 2'b00);
        clear_inputs();
        dec_rd_wr = v.rd_wr; dec_mem_rd = v.mem_rd; dec_mem_wr = v.mem_wr;
        dec_illegal = v.illegal; dec_ebreak = v.ebreak;
        if (retires) sb_q.push_back('{rf: v.exp_rf, ret: exp_ret});

        n = 0;
        while (!ifu_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req_seen", ifu_req_valid, 1);
        if (!ifu_req_valid) return;
        for (int k = 0; k < v.ifu_dly; k++) begin
            tick();
            chk("fetch_valid_hold", ifu_req_valid, 1);
        end
        ifu_req_ready = 1;
        tick();
        ifu_req_ready = 0;
        chk("iwait_no_req", ifu_req_valid, 0);
        for (int k = 0; k < v.rsp_dly; k++) begin
            #1;
            chk("ir_we_early", ir_we, 0);
            tick();
        end
        ifu_rsp_valid = 1;
        ifu_rsp_err = v.ifu_err;
        #1;
        chk("ir_we_pulse", ir_we, int'(!v.ifu_err));
        tick();
        ifu_rsp_valid = 0;
        ifu_rsp_err = 0;
        if (v.ifu_err) begin
            check_stop(v);
            return;
        end

        chk("exec_quiet", {ir_we, pc_we, lsu_req_valid, ifu_req_valid}, 0);
        tick();
        if (v.illegal || v.ebreak) begin
            check_stop(v);
            return;
        end

        if (v.exp_mem) begin
            for (int k = 0; k <= v.lsu_dly; k++) begin
                chk("lsu_req_valid_hold", lsu_req_valid, 1);
                chk("lsu_req_wr", lsu_req_wr, v.exp_wr);
                if (k == v.lsu_dly) lsu_req_ready = 1;
                tick();
            end
            lsu_req_ready = 0;
            chk("mwait_no_req", lsu_req_valid, 0);
            for (int k = 0; k < v.lsu_rsp_dly; k++) tick();
            lsu_rsp_valid = 1;
            lsu_rsp_err = v.lsu_err;
            tick();
            lsu_rsp_valid = 0;
            lsu_rsp_err = 0;
            if (v.lsu_err) begin
                check_stop(v);
                return;
            end
        end else begin
            chk("no_lsu_req", lsu_req_valid, 0);
        end

        chk("wb_pc_we", pc_we, 1);
        tick();
        exp_ret = exp_ret + 1'b1;
        chk("retired_after_wb", retired, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        //                 rd mr mw il eb ie le idl rdl ldl lrdl  rf mem wr halt cause
        ret_tab[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00); // addi
        ret_tab[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 0, 0, 2'b00); // load, ready +3
        ret_tab[2] = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 1, 1, 0, 2'b00); // store
        ret_tab[3] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 2'b00); // store, rd_wr set
        ret_tab[4] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 2'b00); // rd&wr: store wins
        ret_tab[5] = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0,  0, 0, 0, 0, 2'b00); // branch
        ret_tab[6] = mk(1, 0, 0, 0, 0, 0, 0, TMO-1, 0, 0, 0, 1, 0, 0, 0, 2'b00); // ready at expiry
        ret_tab[7] = mk(1, 1, 0, 0, 0, 0, 0, 0, TMO-1, 0, 0, 1, 1, 0, 0, 2'b00); // rsp at expiry
        ret_tab[8] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, TMO-1, 2, 1, 1, 0, 0, 2'b00); // lsu ready at expiry
        ret_tab[9] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, TMO-1, 0, 1, 1, 0, 2'b00); // ack at expiry

        stop_tab[0] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01); // illegal
        stop_tab[1] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01); // illegal wins
        stop_tab[2] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00); // ebreak
        stop_tab[3] = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b11); // fetch bus err
        stop_tab[4] = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 2'b11); // load bus err
        stop_tab[5] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b11); // store bus err
        stop_tab[6] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01); // illegal load

        exp_ret = '0;
        do_reset();

        // addi with every ready/valid tied high
        sb_q.push_back('{rf: 1'b1, ret: exp_ret});
        dec_rd_wr = 1; ifu_req_ready = 1; ifu_rsp_valid = 1;
        lsu_req_ready = 1; lsu_rsp_valid = 1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("tied_ir_we_c%0d", c), ir_we, int'(c == 3));
            chk($sformatf("tied_pc_we_c%0d", c), pc_we, int'(c == 5));
            chk($sformatf("tied_rf_we_c%0d", c), rf_we, int'(c == 5));
            tick();
        end
        clear_inputs();
        exp_ret = exp_ret + 1'b1;
        chk("tied_retired", retired, exp_ret);

        // Two passes so the 4-bit retired counter wraps.
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 10; i++) run_instr(ret_tab[i]);

        // Reset asserted mid-load in MWAIT
        clear_inputs();
        dec_rd_wr = 1; dec_mem_rd = 1;
        chk("mw_fetch", ifu_req_valid, 1);
        ifu_req_ready = 1;
        tick();
        ifu_req_ready = 0; ifu_rsp_valid = 1;
        tick();
        ifu_rsp_valid = 0;
        tick();
        chk("mw_lsu_req", lsu_req_valid, 1);
        lsu_req_ready = 1;
        tick();
        lsu_req_ready = 0;
        chk("mw_retired_before_rst", retired, exp_ret);
        #2;
        rst = 1;
        #1;
        chk_all_zero("mw_async_rst");
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
        exp_ret = '0;
        chk("mw_boot_no_req", ifu_req_valid, 0);
        tick();
        chk("mw_fetch_after_boot", ifu_req_valid, 1);

        // Fetch timeout: ready never arrives
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            chk("tmo_fetch_valid", ifu_req_valid, 1);
        end
        tick();
        chk("tmo_trap", trap, 1);
        chk("tmo_cause", trap_cause, 2);
        chk("tmo_no_req", ifu_req_valid, 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            run_instr(ret_tab[0]);
            run_instr(stop_tab[i]);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
